at_cmd_sender: RTL and testbench
================================

Name: at_cmd_sender

Overview:
- Sequencer directly downstream of the AT-command byte ROM (`cmem`).
- On a start request it walks the ROM address range of the selected modem command and presents each byte to the UART transmitter through a valid/ready handshake.
- For the read-message command (AT+CMGR=) it also appends the message index as ASCII decimal digits, then CR (0x0D).
- Sits between the SMS control FSM (issues start/cmd_sel/msg_idx) and the UART TX block.

Parameters:
- ADDR_W, 7, ROM address width.
- CMD0_BASE, 0, first ROM address of command 0 (AT+CPMS).
- CMD0_LEN, 23, byte count of command 0, including its CR.
- CMD1_BASE, 23, first ROM address of command 1 (AT+CMGD).
- CMD1_LEN, 11, byte count of command 1, including its CR.
- CMD2_BASE, 34, first ROM address of command 2 (AT+CSDH).
- CMD2_LEN, 10, byte count of command 2, including its CR.
- CMD3_BASE, 44, first ROM address of command 3 (AT+CMGR=).
- CMD3_LEN, 8, byte count of command 3 (no CR in ROM).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only when busy=0.
- cmd_sel  in  2  command select, captured with start.
- msg_idx  in  7  message index for cmd 3, binary; legal range 1..99; captured with start.
- rom_addr  out  ADDR_W  address to the ROM.
- rom_data  in  8  ROM byte; valid one cycle after rom_addr changes.
- tx_data  out  8  byte to the UART.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART accepts the byte.
- busy  out  1  a sequence is in progress.
- done  out  1  one-cycle pulse after the final byte handshake.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (synchronous, active-high) takes effect at the next clk edge, from any state:
  - state to IDLE;
  - rom_addr=0, tx_data=0x00, tx_valid=0, busy=0, done=0, err=0.
  - Reset mid-sequence abandons the command. tx_valid may drop without a handshake only in this case.
- States: IDLE, FETCH, SEND, IDX_T, IDX_U, CR, FIN.
- IDLE:
  - start=1 with cmd_sel=3 and msg_idx 0 or >99: err=1 for one cycle, remain IDLE, no tx_valid.
  - start=1 otherwise:
    - latch cmd_sel and msg_idx;
    - rom_addr <= CMDn_BASE;
    - remaining count <= CMDn_LEN;
    - busy=1 from the next cycle;
    - go to FETCH.
- FETCH:
  - one wait cycle for ROM latency;
  - tx_data <= rom_data, tx_valid <= 1;
  - go to SEND.
- SEND:
  - tx_data and tx_valid held stable until a cycle with tx_valid & tx_ready. That cycle is the handshake; it transfers exactly one byte.
  - On handshake with count>1: rom_addr+1, count-1, tx_valid <= 0, go to FETCH.
  - On handshake with the last byte of cmd 0/1/2: tx_valid <= 0, go to FIN.
  - On handshake with the last byte of cmd 3:
    - msg_idx ≥ 10: tx_data <= 0x30+tens, tx_valid <= 1, go to IDX_T.
    - msg_idx < 10: tx_data <= 0x30+units, tx_valid <= 1, go to IDX_U (tens digit suppressed).
- IDX_T: on handshake, tx_data <= 0x30+units, go to IDX_U.
- IDX_U: on handshake, tx_data <= 0x0D, go to CR.
- CR: on handshake, tx_valid <= 0, go to FIN.
- tens/units: computed from the latched msg_idx by comparison/subtraction, no divider. tens ∈ 0..9, units = msg_idx − 10·tens.
- FIN:
  - done=1 and busy=0 for exactly this cycle, then IDLE.
  - start is not accepted in FIN; first acceptance is in the following IDLE cycle.
- start while busy=1: ignored, no err.
- Throughput with tx_ready tied high:
  - ROM bytes: one every 2 cycles; the first tx_valid is 2 cycles after the start-accept edge.
  - Digit and CR bytes: back-to-back, one per cycle.
- rom_addr does not wrap; its maximum value is BASE+LEN−1 ≤ 2^ADDR_W−1.
- tx_data is never X while tx_valid=1.

Test Plan:
- rst, cmd_sel=2, start, tx_ready=1:
  - tx bytes 41 54 2B 43 53 44 48 3D 31 0D, in that order;
  - tx_valid on the 2nd, 4th, …, 20th cycle after the accept edge;
  - done pulse on the 21st;
  - busy low after.
- cmd_sel=3, msg_idx=7, tx_ready=1 → 41 54 2B 43 4D 47 52 3D 37 0D; done once; no tens digit.
- cmd_sel=3, msg_idx=42 → ROM bytes then 34 32 0D. Repeat with msg_idx=99 → 39 39 0D; msg_idx=10 → 31 30 0D.
- cmd_sel=3, msg_idx=0 and msg_idx=100 → err one cycle each; tx_valid stays 0; busy stays 0.
- cmd_sel=0, tx_ready low for 5 cycles while the 3rd byte (0x2B) is presented:
  - tx_data holds 0x2B and tx_valid stays 1 throughout the stall;
  - exactly 23 handshakes in total, matching ROM 0..22, none duplicated or skipped.
- cmd_sel=1 with rst asserted after the 6th handshake:
  - next cycle tx_valid=0, busy=0, rom_addr=0;
  - a subsequent start with cmd_sel=2 produces the full 10-byte sequence;
  - a start pulsed mid-sequence is ignored.

Source files
------------

// File: rtl/at_cmd_sender.sv
// AT-command sequencer: walks the ROM span of the selected command and streams
// each byte to the UART over valid/ready, appending "<index>\r" for AT+CMGR=.
module at_cmd_sender #(
  parameter int ADDR_W    = 7,
  parameter int CMD0_BASE = 0,
  parameter int CMD0_LEN  = 23,
  parameter int CMD1_BASE = 23,
  parameter int CMD1_LEN  = 11,
  parameter int CMD2_BASE = 34,
  parameter int CMD2_LEN  = 10,
  parameter int CMD3_BASE = 44,
  parameter int CMD3_LEN  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        cmd_sel_i,
  input  logic [6:0]        msg_idx_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [7:0]        rom_data_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    IDX_T = 3'd3,
    IDX_U = 3'd4,
    CR    = 3'd5,
    FIN   = 3'd6
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [7:0]        cnt_q;
  logic [1:0]        cmd_q;
  logic [6:0]        idx_q;
  logic              settle_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [3:0]        tens_s;
  logic [3:0]        units_s;
  logic              hs_s;

  function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return ADDR_W'(CMD0_BASE);
      2'd1:    return ADDR_W'(CMD1_BASE);
      2'd2:    return ADDR_W'(CMD2_BASE);
      2'd3:    return ADDR_W'(CMD3_BASE);
      default: return ADDR_W'(CMD0_BASE);
    endcase
  endfunction

  function automatic logic [7:0] len_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return 8'(CMD0_LEN);
      2'd1:    return 8'(CMD1_LEN);
      2'd2:    return 8'(CMD2_LEN);
      2'd3:    return 8'(CMD3_LEN);
      default: return 8'(CMD0_LEN);
    endcase
  endfunction

  // Tens digit by threshold comparison; the index never exceeds 99 here.
  function automatic logic [3:0] tens_of(input logic [6:0] v);
    logic [3:0] t;
    t = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (v >= 7'(10 * k)) t = 4'(k);
      else                 t = t;
    end
    return t;
  endfunction

  // Decimal split of the latched index and the handshake strobe.
  always_comb begin
    tens_s  = tens_of(idx_q);
    units_s = 4'(idx_q - ({3'd0, tens_s} << 3) - ({3'd0, tens_s} << 1));
    hs_s    = tx_valid_q & tx_ready_i;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      cnt_q      <= 8'd0;
      cmd_q      <= 2'd0;
      idx_q      <= 7'd0;
      settle_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (cmd_sel_i == 2'd3 && (msg_idx_i == 7'd0 || msg_idx_i > 7'd99)) begin
              err_q <= 1'b1;
            end else begin
              cmd_q      <= cmd_sel_i;
              idx_q      <= msg_idx_i;
              rom_addr_q <= base_of(cmd_sel_i);
              cnt_q      <= len_of(cmd_sel_i);
              busy_q     <= 1'b1;
              settle_q   <= 1'b1;
              state_q    <= FETCH;
            end
          end
        end
        FETCH: begin
          // The first byte of a command gets one extra cycle after the base jump.
          if (settle_q) begin
            settle_q <= 1'b0;
          end else begin
            tx_data_q  <= rom_data_i;
            tx_valid_q <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (hs_s) begin
            if (cnt_q > 8'd1) begin
              rom_addr_q <= rom_addr_q + 1'b1;
              cnt_q      <= cnt_q - 8'd1;
              tx_valid_q <= 1'b0;
              state_q    <= FETCH;
            end else if (cmd_q != 2'd3) begin
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= FIN;
            end else if (idx_q >= 7'd10) begin
              tx_data_q <= 8'h30 + {4'd0, tens_s};
              state_q   <= IDX_T;
            end else begin
              tx_data_q <= 8'h30 + {4'd0, units_s};
              state_q   <= IDX_U;
            end
          end
        end
        IDX_T: begin
          if (hs_s) begin
            tx_data_q <= 8'h30 + {4'd0, units_s};
            state_q   <= IDX_U;
          end
        end
        IDX_U: begin
          if (hs_s) begin
            tx_data_q <= 8'h0D;
            state_q   <= CR;
          end
        end
        CR: begin
          if (hs_s) begin
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= FIN;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rom_addr_o = rom_addr_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_at_cmd_sender.sv
// Self-checking bench for at_cmd_sender: command strings drive both the ROM
// image and the expected byte stream, checked against captured handshakes.
module tb_at_cmd_sender;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] cmd_sel;
  logic [6:0] msg_idx;
  logic [6:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [7:0] rom [0:127];
  logic [7:0] got [$];
  int done_cnt = 0;
  int err_cnt  = 0;

  string cmd_text [4];
  int    cmd_base [4];

  at_cmd_sender dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cmd_sel_i(cmd_sel),
    .msg_idx_i(msg_idx), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  // Handshake capture: inputs change 1 ns after posedge, so negedge values hold at the edge.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) got.push_back(tx_data);
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  function automatic void build_expected(input int cmd, input int idx, output logic [7:0] q [$]);
    string s;
    q = {};
    s = cmd_text[cmd];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    if (cmd != 3) q.push_back(8'h0D);
    else begin
      if (idx >= 10) q.push_back(8'(8'h30 + idx / 10));
      q.push_back(8'(8'h30 + idx % 10));
      q.push_back(8'h0D);
    end
  endfunction

  task automatic clear_log();
    got = {};
    done_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic pulse_start(input logic [1:0] c, input logic [6:0] idx);
    start = 1'b1; cmd_sel = c; msg_idx = idx;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs until done is seen or the bound expires; optional random ready and stray starts.
  task automatic drive_until_done(input int bound, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound && !ok; n++) begin
      if (rnd) begin
        tx_ready = ($urandom_range(0, 3) != 0);
        start    = ($urandom_range(0, 7) == 0);
        cmd_sel  = 2'($urandom_range(0, 3));
        msg_idx  = 7'($urandom_range(0, 127));
      end
      @(posedge clk); #1;
      if (done) ok = 1'b1;
    end
    start = 1'b0;
    tx_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic compare_stream(input string name, input logic [7:0] exp_q [$]);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s byte count: got %0d required %0d", name, got.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (got[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s byte %0d: got %02h required %02h", name, i, got[i], exp_q[i]);
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({tx_valid, busy, done, err} !== 4'b0000 || rom_addr !== 7'd0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset: valid/busy/done/err=%b addr=%0d data=%02h required 0000 0 00",
               {tx_valid, busy, done, err}, rom_addr, tx_data);
    end
  endtask

  task automatic test_cmd2_timing();
    logic [7:0] exp_q [$];
    bit bad;
    int bad_k;
    clear_log();
    tx_ready = 1'b1;
    pulse_start(2'd2, 7'd0);
    bad = 1'b0; bad_k = 0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (!bad && (tx_valid !== ((k % 2 == 0) && k <= 20) || done !== (k == 21) ||
                   busy !== (k <= 20))) begin
        bad = 1'b1; bad_k = k;
      end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL cmd2 timing: mismatch at cycle %0d valid=%b done=%b busy=%b", bad_k, tx_valid, done, busy);
    end
    build_expected(2, 0, exp_q);
    compare_stream("cmd2 bytes", exp_q);
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL cmd2 done count: got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_msg_index();
    int idx_list [4] = '{7, 42, 99, 10};
    logic [7:0] exp_q [$];
    bit ok;
    foreach (idx_list[i]) begin
      clear_log();
      tx_ready = 1'b1;
      pulse_start(2'd3, 7'(idx_list[i]));
      drive_until_done(100, 1'b0, ok);
      checks++;
      if (!ok || done_cnt != 1) begin
        errors++;
        $display("FAIL cmgr idx %0d done: seen=%b count=%0d required 1", idx_list[i], ok, done_cnt);
      end
      build_expected(3, idx_list[i], exp_q);
      compare_stream("cmgr bytes", exp_q);
    end
  endtask

  task automatic test_bad_index();
    int bad_list [2] = '{0, 100};
    foreach (bad_list[i]) begin
      clear_log();
      pulse_start(2'd3, 7'(bad_list[i]));
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL bad idx %0d: err=%b busy=%b valid=%b required 1 0 0", bad_list[i], err, busy, tx_valid);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0 || err_cnt != 1 || got.size() != 0) begin
        errors++;
        $display("FAIL bad idx %0d after: err=%b busy=%b valid=%b errs=%0d bytes=%0d required 0 0 0 1 0",
                 bad_list[i], err, busy, tx_valid, err_cnt, got.size());
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_q [$];
    bit stalled, hold_bad, seen_done;
    clear_log();
    tx_ready = 1'b1;
    pulse_start(2'd0, 7'd0);
    stalled = 1'b0; hold_bad = 1'b0; seen_done = 1'b0;
    for (int n = 0; n < 120 && !seen_done; n++) begin
      if (!stalled && tx_valid && tx_data == 8'h2B) begin
        stalled = 1'b1;
        tx_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk); #1;
          if (tx_valid !== 1'b1 || tx_data !== 8'h2B) hold_bad = 1'b1;
        end
        tx_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    if (!stalled || hold_bad) begin
      errors++;
      $display("FAIL stall hold: stall_reached=%b hold_broken=%b required 1 0", stalled, hold_bad);
    end
    build_expected(0, 0, exp_q);
    compare_stream("cpms stalled bytes", exp_q);
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_q [$];
    bit ok;
    int n;
    clear_log();
    tx_ready = 1'b1;
    pulse_start(2'd1, 7'd0);
    n = 0;
    while (got.size() < 6 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (got.size() != 6 || tx_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 7'd0) begin
      errors++;
      $display("FAIL mid reset: bytes=%0d valid=%b busy=%b addr=%0d required 6 0 0 0",
               got.size(), tx_valid, busy, rom_addr);
    end
    clear_log();
    pulse_start(2'd2, 7'd0);
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; end
    pulse_start(2'd0, 7'd0);
    drive_until_done(100, 1'b0, ok);
    build_expected(2, 0, exp_q);
    compare_stream("post reset cmd2", exp_q);
    checks++;
    if (!ok || done_cnt != 1 || err_cnt != 0) begin
      errors++;
      $display("FAIL post reset done/err: seen=%b done=%0d err=%0d required 1 1 0", ok, done_cnt, err_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q [$];
    int c, idx;
    bit ok;
    for (int it = 0; it < 24; it++) begin
      c = $urandom_range(0, 3);
      idx = $urandom_range(1, 99);
      if (it % 6 == 5) idx = $urandom_range(100, 127);
      clear_log();
      tx_ready = 1'b1;
      pulse_start(2'(c), 7'(idx));
      if (c == 3 && idx > 99) begin
        @(posedge clk); #1;
        checks++;
        if (err_cnt != 1 || busy !== 1'b0 || got.size() != 0) begin
          errors++;
          $display("FAIL random reject idx %0d: errs=%0d busy=%b bytes=%0d required 1 0 0", idx, err_cnt, busy, got.size());
        end
      end else begin
        drive_until_done(400, 1'b1, ok);
        build_expected(c, idx, exp_q);
        compare_stream("random stream", exp_q);
        checks++;
        if (!ok || done_cnt != 1 || err_cnt != 0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL random cmd %0d idx %0d: seen=%b done=%0d err=%0d busy=%b required 1 1 0 0",
                   c, idx, ok, done_cnt, err_cnt, busy);
        end
      end
    end
  endtask

  initial begin
    cmd_text[0] = "AT+CPMS=\"SM\",\"SM\",\"SM\"";
    cmd_text[1] = "AT+CMGD=14";
    cmd_text[2] = "AT+CSDH=1";
    cmd_text[3] = "AT+CMGR=";
    cmd_base = '{0, 23, 34, 44};
    for (int a = 0; a < 128; a++) rom[a] = 8'hEE;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < cmd_text[c].len(); i++) rom[cmd_base[c] + i] = cmd_text[c][i];
      if (c != 3) rom[cmd_base[c] + cmd_text[c].len()] = 8'h0D;
    end
    rst = 1'b1; start = 1'b0; cmd_sel = 2'd0; msg_idx = 7'd0; tx_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_cmd2_timing();
    test_msg_index();
    test_bad_index();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
